// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a 16-bit op on an external 4-bit 74181, LSB nibble first.
// Optional AEB accumulation via `define ALU_SEQ_EQ_EN (default: eq tied low).
//
// Ports:
//   i_clock, i_reset (async, active-high)
//   i_start, i_op_a/i_op_b (16), i_op_s (4), i_op_m, i_op_cnb : request + operands
//   o_busy, o_done, o_result (16), o_cout_b, o_zero, o_eq       : status/result
//   o_alu_s/a/b (4), o_alu_m, o_alu_cnb                         : drives to 74181
//   i_alu_f (4), i_alu_cn4b, i_alu_aeb                          : returns from 74181
module alu_nibble_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_op_a,
  input  logic [15:0] i_op_b,
  input  logic [3:0]  i_op_s,
  input  logic        i_op_m,
  input  logic        i_op_cnb,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result,
  output logic        o_cout_b,
  output logic        o_zero,
  output logic        o_eq,
  output logic [3:0]  o_alu_s,
  output logic [3:0]  o_alu_a,
  output logic [3:0]  o_alu_b,
  output logic        o_alu_m,
  output logic        o_alu_cnb,
  input  logic [3:0]  i_alu_f,
  input  logic        i_alu_cn4b,
  input  logic        i_alu_aeb
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_nib;
  logic [3:0]  r_cnt;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_s;
  logic        r_m;
  logic        r_cnb;
  logic        r_carry;
  logic [15:0] r_acc;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_result;
  logic        r_cout_b;
  logic        r_zero;

  logic [15:0] w_acc_next;
  logic [3:0]  w_idx;

  assign w_idx = {r_nib, 2'b00};

  // Staging accumulator with the current nibble merged in; the visible
  // result only updates once the whole word is done.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[w_idx +: 4] = i_alu_f;
  end

  assign o_alu_a   = r_a[w_idx +: 4];
  assign o_alu_b   = r_b[w_idx +: 4];
  assign o_alu_s   = r_s;
  assign o_alu_m   = r_m;
  assign o_alu_cnb = (r_nib == 2'd0) ? r_cnb : r_carry;

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_cout_b = r_cout_b;
  assign o_zero   = r_zero;

`ifdef ALU_SEQ_EQ_EN
  logic r_eq_acc;
  logic r_eq;
  assign o_eq = r_eq;
`else
  logic w_unused_aeb;
  assign w_unused_aeb = i_alu_aeb;
  assign o_eq = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_nib    <= 2'd0;
      r_cnt    <= 4'd0;
      r_a      <= 16'h0000;
      r_b      <= 16'h0000;
      r_s      <= 4'h0;
      r_m      <= 1'b1;
      r_cnb    <= 1'b1;
      r_carry  <= 1'b1;
      r_acc    <= 16'h0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 16'h0000;
      r_cout_b <= 1'b1;
      r_zero   <= 1'b0;
`ifdef ALU_SEQ_EQ_EN
      r_eq_acc <= 1'b0;
      r_eq     <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_s     <= i_op_s;
            r_m     <= i_op_m;
            r_cnb   <= i_op_cnb;
            r_nib   <= 2'd0;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
`ifdef ALU_SEQ_EQ_EN
            r_eq_acc <= 1'b1;
`endif
          end
        end
        S_SETTLE: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_acc   <= w_acc_next;
            r_carry <= i_alu_cn4b;
`ifdef ALU_SEQ_EQ_EN
            r_eq_acc <= r_eq_acc & i_alu_aeb;
`endif
            if (r_nib == 2'd3) begin
              r_result <= w_acc_next;
              r_cout_b <= i_alu_cn4b;
              r_zero   <= (w_acc_next == 16'h0000);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
`ifdef ALU_SEQ_EQ_EN
              r_eq <= r_eq_acc & i_alu_aeb;
`endif
            end else begin
              r_nib <= r_nib + 2'd1;
              r_cnt <= CNT_LOAD;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed bench with a behavioral 74181 on the ALU port.
// Expected values are hand-computed constants.
module tb_alu_nibble_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_s;
  logic        op_m;
  logic        op_cnb;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout_b;
  logic        zero;
  logic        eq;
  logic [3:0]  alu_s;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic        alu_m;
  logic        alu_cnb;
  logic [3:0]  alu_f;
  logic        alu_cn4b;
  logic        alu_aeb;

  int tests = 0;
  int fails = 0;

  int         g_done_cyc;
  int         g_n_done;
  bit         g_busy_gap;
  logic [3:0] g_anib [4];

  alu_nibble_sequencer dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_start   (start),
    .i_op_a    (op_a),
    .i_op_b    (op_b),
    .i_op_s    (op_s),
    .i_op_m    (op_m),
    .i_op_cnb  (op_cnb),
    .o_busy    (busy),
    .o_done    (done),
    .o_result  (result),
    .o_cout_b  (cout_b),
    .o_zero    (zero),
    .o_eq      (eq),
    .o_alu_s   (alu_s),
    .o_alu_a   (alu_a),
    .o_alu_b   (alu_b),
    .o_alu_m   (alu_m),
    .o_alu_cnb (alu_cnb),
    .i_alu_f   (alu_f),
    .i_alu_cn4b(alu_cn4b),
    .i_alu_aeb (alu_aeb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioral 74181, active-high data, active-low carries.
  always_comb begin
    logic [4:0] x;
    logic [4:0] y;
    logic [4:0] sum;
    x = {1'b0, alu_a};
    y = 5'd0;
    alu_f = 4'h0;
    alu_cn4b = 1'b1;
    if (alu_m) begin
      case (alu_s)
        4'h0: alu_f = ~alu_a;
        4'h1: alu_f = ~(alu_a | alu_b);
        4'h2: alu_f = ~alu_a & alu_b;
        4'h3: alu_f = 4'h0;
        4'h4: alu_f = ~(alu_a & alu_b);
        4'h5: alu_f = ~alu_b;
        4'h6: alu_f = alu_a ^ alu_b;
        4'h7: alu_f = alu_a & ~alu_b;
        4'h8: alu_f = ~alu_a | alu_b;
        4'h9: alu_f = ~(alu_a ^ alu_b);
        4'hA: alu_f = alu_b;
        4'hB: alu_f = alu_a & alu_b;
        4'hC: alu_f = 4'hF;
        4'hD: alu_f = alu_a | ~alu_b;
        4'hE: alu_f = alu_a | alu_b;
        default: alu_f = alu_a;
      endcase
    end else begin
      case (alu_s)
        4'h6: y = {1'b0, ~alu_b};
        4'h9: y = {1'b0, alu_b};
        4'hC: y = {1'b0, alu_a};
        4'hF: y = 5'h0F;
        default: y = 5'd0;
      endcase
      sum = x + y + {4'd0, ~alu_cnb};
      alu_f = sum[3:0];
      alu_cn4b = ~sum[4];
    end
    alu_aeb = &alu_f;
  end

  // Issues one op at a negedge, then watches 20 cycles (cycle k follows edge E(k-1)).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic m, input logic cnb,
                       input bit inject);
    g_done_cyc = 0;
    g_n_done = 0;
    g_busy_gap = 1'b0;
    @(negedge clk);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cnb = cnb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 8 && (k % 2) == 1) g_anib[(k - 1) / 2] = alu_a;
      if (done) begin
        g_n_done++;
        if (g_done_cyc == 0) g_done_cyc = k;
      end
      if (k <= 9 && !busy) g_busy_gap = 1'b1;
      if (inject && k == 3) begin
        op_a = 16'h0F0F; op_b = 16'h0101; op_s = 4'h6; op_m = 1'b1;
        start = 1'b1;
      end
      if (inject && k == 4) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done got %b want 0", done); end
    tests++; if (result !== 16'h0000) begin fails++; $display("FAIL rst_result got %h want 0000", result); end
    tests++; if (cout_b !== 1'b1) begin fails++; $display("FAIL rst_cout_b got %b want 1", cout_b); end
    tests++; if (zero !== 1'b0) begin fails++; $display("FAIL rst_zero got %b want 0", zero); end
    tests++; if (eq !== 1'b0) begin fails++; $display("FAIL rst_eq got %b want 0", eq); end
    tests++; if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_s !== 4'h0) begin
      fails++; $display("FAIL rst_alu_abs got %h %h %h want 0 0 0", alu_a, alu_b, alu_s); end
    tests++; if (alu_m !== 1'b1) begin fails++; $display("FAIL rst_alu_m got %b want 1", alu_m); end
    tests++; if (alu_cnb !== 1'b1) begin fails++; $display("FAIL rst_alu_cnb got %b want 1", alu_cnb); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    do_op(16'h1234, 16'h4321, 4'h9, 1'b0, 1'b1, 1'b0);
    tests++; if (result !== 16'h5555) begin fails++; $display("FAIL add_result got %h want 5555", result); end
    tests++; if (cout_b !== 1'b1) begin fails++; $display("FAIL add_cout_b got %b want 1", cout_b); end
    tests++; if (zero !== 1'b0) begin fails++; $display("FAIL add_zero got %b want 0", zero); end
    tests++; if (eq !== 1'b0) begin fails++; $display("FAIL add_eq got %b want 0", eq); end
    tests++; if (g_done_cyc !== 9) begin fails++; $display("FAIL add_done_cycle got %0d want 9", g_done_cyc); end
    tests++; if (g_n_done !== 1) begin fails++; $display("FAIL add_done_count got %0d want 1", g_n_done); end
    tests++; if (g_busy_gap || busy !== 1'b0) begin
      fails++; $display("FAIL add_busy got gap=%b end=%b want 0 0", g_busy_gap, busy); end
  endtask

  task automatic test_carry_ripple;
    do_op(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b1, 1'b0);
    tests++; if (result !== 16'h0000) begin fails++; $display("FAIL carry_result got %h want 0000", result); end
    tests++; if (cout_b !== 1'b0) begin fails++; $display("FAIL carry_cout_b got %b want 0", cout_b); end
    tests++; if (zero !== 1'b1) begin fails++; $display("FAIL carry_zero got %b want 1", zero); end
  endtask

  task automatic test_compare;
    logic exp_eq;
`ifdef ALU_SEQ_EQ_EN
    exp_eq = 1'b1;
`else
    exp_eq = 1'b0;
`endif
    do_op(16'h3C3C, 16'h3C3C, 4'h6, 1'b0, 1'b1, 1'b0);
    tests++; if (result !== 16'hFFFF) begin fails++; $display("FAIL cmp_result got %h want FFFF", result); end
    tests++; if (eq !== exp_eq) begin fails++; $display("FAIL cmp_eq got %b want %b", eq, exp_eq); end
    tests++; if (zero !== 1'b0) begin fails++; $display("FAIL cmp_zero got %b want 0", zero); end
  endtask

  task automatic test_logic_xor;
    do_op(16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b1, 1'b0);
    tests++; if (result !== 16'h0FF0) begin fails++; $display("FAIL xor_result got %h want 0FF0", result); end
    tests++; if (g_anib[0] !== 4'h0) begin fails++; $display("FAIL xor_alu_a0 got %h want 0", g_anib[0]); end
    tests++; if (g_anib[1] !== 4'hF) begin fails++; $display("FAIL xor_alu_a1 got %h want F", g_anib[1]); end
    tests++; if (g_anib[2] !== 4'h0) begin fails++; $display("FAIL xor_alu_a2 got %h want 0", g_anib[2]); end
    tests++; if (g_anib[3] !== 4'hF) begin fails++; $display("FAIL xor_alu_a3 got %h want F", g_anib[3]); end
  endtask

  task automatic test_handshake;
    do_op(16'h1111, 16'h2222, 4'h9, 1'b0, 1'b1, 1'b1);
    tests++; if (result !== 16'h3333) begin fails++; $display("FAIL hs_result got %h want 3333", result); end
    tests++; if (g_n_done !== 1) begin fails++; $display("FAIL hs_done_count got %0d want 1", g_n_done); end
    tests++; if (g_done_cyc !== 9) begin fails++; $display("FAIL hs_done_cycle got %0d want 9", g_done_cyc); end
    tests++; if (g_busy_gap) begin fails++; $display("FAIL hs_busy got gap=1 want 0"); end
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    op_a = 16'h1000; op_b = 16'h0234; op_s = 4'h9; op_m = 1'b0; op_cnb = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 5; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL mid_done got %b want 0", done); end
    tests++; if (result !== 16'h0000) begin fails++; $display("FAIL mid_result got %h want 0000", result); end
    tests++; if (cout_b !== 1'b1) begin fails++; $display("FAIL mid_cout_b got %b want 1", cout_b); end
    tests++; if (alu_cnb !== 1'b1) begin fails++; $display("FAIL mid_alu_cnb got %b want 1", alu_cnb); end
    tests++; if (alu_m !== 1'b1) begin fails++; $display("FAIL mid_alu_m got %b want 1", alu_m); end
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h0100, 16'h0023, 4'h9, 1'b0, 1'b1, 1'b0);
    tests++; if (result !== 16'h0123) begin fails++; $display("FAIL mid_after_result got %h want 0123", result); end
    tests++; if (g_done_cyc !== 9) begin fails++; $display("FAIL mid_after_done got %0d want 9", g_done_cyc); end
  endtask

  task automatic test_back_to_back;
    int d1;
    int d2;
    int nd;
    d1 = 0; d2 = 0; nd = 0;
    @(negedge clk);
    op_a = 16'h0808; op_b = 16'h0808; op_s = 4'h9; op_m = 1'b0; op_cnb = 1'b1;
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 11) start = 1'b0;
      if (done) begin
        nd++;
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
      end
    end
    tests++; if (d1 !== 9 || d2 !== 19) begin
      fails++; $display("FAIL b2b_done_cycles got %0d %0d want 9 19", d1, d2); end
    tests++; if (nd !== 2) begin fails++; $display("FAIL b2b_done_count got %0d want 2", nd); end
    tests++; if (result !== 16'h1010) begin fails++; $display("FAIL b2b_result got %h want 1010", result); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op_a = 16'h0; op_b = 16'h0; op_s = 4'h0; op_m = 1'b0; op_cnb = 1'b1;
    test_reset();
    test_add();
    test_carry_ripple();
    test_compare();
    test_logic_xor();
    test_handshake();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
